// File: rtl/sensor_frame_sequencer.sv
// sensor_frame_sequencer
// Reads sensor registers FIRST_ADDR..LAST_ADDR once per frame. Sends each frame as a
// valid/ready byte stream: a SYNC_BYTE header followed by one byte per register.
// A frame is started by a start pulse or by the internal period timer.
// Optional feature: define SEQ_CHECKSUM_EN to append a checksum byte to each frame.
// The checksum byte makes the 8-bit sum of the payload bytes plus the checksum equal 0.
module sensor_frame_sequencer #(
  parameter logic [7:0] FIRST_ADDR = 8'd1,
  parameter logic [7:0] LAST_ADDR  = 8'd25,
  parameter logic [7:0] SYNC_BYTE  = 8'hA5,
  parameter int         PERIOD     = 50000,
  parameter int         RD_WAIT    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       auto_en,
  output logic [7:0] reg_addr,
  input  logic [7:0] reg_data,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       frame_done,
  output logic       overrun
);

  localparam int CNT_W  = (PERIOD > 2) ? $clog2(PERIOD) : 1;
  localparam int WAIT_W = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] SYNC = 3'd1;
  localparam logic [2:0] WAIT = 3'd2;
  localparam logic [2:0] SEND = 3'd3;
  localparam logic [2:0] DONE = 3'd4;
`ifdef SEQ_CHECKSUM_EN
  localparam logic [2:0] CSUM = 3'd5;
`endif

  logic [2:0]        state;
  logic [7:0]        addr;
  logic [WAIT_W-1:0] wait_cnt;
  logic [CNT_W-1:0]  period_cnt;
  logic              period_tick;
  logic              trigger;
  logic              wait_done;

  assign period_tick = auto_en && (period_cnt == CNT_W'(PERIOD - 1));
  assign trigger     = start | period_tick;
  assign wait_done   = (wait_cnt == WAIT_W'(RD_WAIT - 1));

  // Free-running frame period timer; it keeps running while a frame is in progress.
  // Clearing auto_en holds the timer at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_cnt <= '0;
    end else if (!auto_en) begin
      period_cnt <= '0;
    end else if (period_cnt == CNT_W'(PERIOD - 1)) begin
      period_cnt <= '0;
    end else begin
      period_cnt <= period_cnt + 1'b1;
    end
  end

`ifdef SEQ_CHECKSUM_EN
  logic [7:0] checksum;

  // Running 8-bit sum of the payload bytes. The SYNC header is not included.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      checksum <= 8'd0;
    end else if (state == IDLE && trigger) begin
      checksum <= 8'd0;
    end else if (state == WAIT && wait_done) begin
      checksum <= checksum + reg_data;
    end
  end
`endif

  // Frame sequencer. Once tx_valid is raised, tx_data is only changed after the byte
  // has been accepted. A trigger that arrives outside IDLE is dropped and flagged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      addr       <= 8'd0;
      wait_cnt   <= '0;
      reg_addr   <= 8'd0;
      tx_data    <= 8'd0;
      tx_valid   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      overrun    <= trigger && (state != IDLE);
      case (state)
        IDLE: begin
          reg_addr <= 8'd0;
          if (trigger) begin
            busy     <= 1'b1;
            tx_data  <= SYNC_BYTE;
            tx_valid <= 1'b1;
            addr     <= FIRST_ADDR;
            state    <= SYNC;
          end
        end
        SYNC: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            reg_addr <= addr;
            wait_cnt <= '0;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (wait_done) begin
            tx_data  <= reg_data;
            tx_valid <= 1'b1;
            state    <= SEND;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        SEND: begin
          if (tx_ready) begin
            if (addr == LAST_ADDR) begin
`ifdef SEQ_CHECKSUM_EN
              // The running sum already includes the byte that was just accepted.
              tx_data  <= 8'd0 - checksum;
              tx_valid <= 1'b1;
              state    <= CSUM;
`else
              tx_valid <= 1'b0;
              state    <= DONE;
`endif
            end else begin
              addr     <= addr + 8'd1;
              reg_addr <= addr + 8'd1;
              tx_valid <= 1'b0;
              wait_cnt <= '0;
              state    <= WAIT;
            end
          end
        end
`ifdef SEQ_CHECKSUM_EN
        CSUM: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            state    <= DONE;
          end
        end
`endif
        DONE: begin
          frame_done <= 1'b1;
          busy       <= 1'b0;
          reg_addr   <= 8'd0;
          tx_valid   <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          tx_valid <= 1'b0;
          reg_addr <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sensor_frame_sequencer.sv
// Testbench for sensor_frame_sequencer.
// A frame-level model predicts the byte stream and the busy, frame_done and overrun
// outputs. The model is checked against the design on every cycle. Directed scenarios
// also check literal byte values.
module tb_sensor_frame_sequencer;

  localparam int PERIOD = 100;
`ifdef SEQ_CHECKSUM_EN
  localparam int FLEN = 27;
`else
  localparam int FLEN = 26;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       auto_en = 1'b0;
  logic       tx_ready = 1'b0;
  logic [7:0] reg_addr, reg_data, tx_data;
  logic       tx_valid, busy, frame_done, overrun;

  // Register bank model: each register returns its own address XOR 0x5A.
  assign reg_data = reg_addr ^ 8'h5A;

  sensor_frame_sequencer #(
    .FIRST_ADDR(8'd1), .LAST_ADDR(8'd25), .SYNC_BYTE(8'hA5),
    .PERIOD(PERIOD), .RD_WAIT(1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .auto_en(auto_en),
    .reg_addr(reg_addr), .reg_data(reg_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .frame_done(frame_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model and observation log.
  logic [7:0] exp_q[$];
  int         m_phase;   // 0 = accepting triggers, 1 = frame in flight, 2 = wrap-up cycle
  int         m_left;
  logic       m_busy, m_fd, m_ov;
  int         m_cnt;
  logic       prev_stall;
  logic [7:0] prev_data;
  int         fd_count = 0;
  int         ov_count = 0;
  logic [7:0] log_mem[0:1023];
  int         log_len = 0;

  task automatic push_frame();
    logic [7:0] s;
    logic [7:0] b;
    s = 8'd0;
    exp_q.push_back(8'hA5);
    for (int a = 1; a <= 25; a++) begin
      b = 8'(a) ^ 8'h5A;
      s = s + b;
      exp_q.push_back(b);
    end
`ifdef SEQ_CHECKSUM_EN
    exp_q.push_back(8'd0 - s);
`endif
  endtask

  // Per-cycle compare. Outputs are sampled on the falling edge, then the model is advanced.
  always @(negedge clk) begin
    logic       trig;
    logic [7:0] eb;
    if (rst) begin
      exp_q.delete();
      m_phase = 0; m_left = 0; m_busy = 1'b0; m_fd = 1'b0; m_ov = 1'b0; m_cnt = 0;
      prev_stall = 1'b0; prev_data = 8'd0;
    end else begin
      chk("busy", {31'd0, busy}, {31'd0, m_busy});
      chk("frame_done", {31'd0, frame_done}, {31'd0, m_fd});
      chk("overrun", {31'd0, overrun}, {31'd0, m_ov});
      if (m_phase == 0) chk("reg_addr_idle", {24'd0, reg_addr}, 32'd0);
      if (prev_stall) begin
        chk("hold_valid", {31'd0, tx_valid}, 32'd1);
        chk("hold_data", {24'd0, tx_data}, {24'd0, prev_data});
      end
      if (tx_valid && tx_ready) begin
        if (m_phase != 1 || exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL extra_byte: got %0h expected no byte at %0t", tx_data, $time);
        end else begin
          eb = exp_q.pop_front();
          chk("tx_data", {24'd0, tx_data}, {24'd0, eb});
          m_left--;
        end
        if (log_len < 1024) log_mem[log_len] = tx_data;
        log_len++;
      end
      if (frame_done) fd_count++;
      if (overrun) ov_count++;
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;

      trig = start || (auto_en && m_cnt == PERIOD - 1);
      m_fd = 1'b0;
      m_ov = 1'b0;
      case (m_phase)
        0: if (trig) begin push_frame(); m_left = FLEN; m_phase = 1; m_busy = 1'b1; end
        1: begin if (trig) m_ov = 1'b1; if (m_left == 0) m_phase = 2; end
        default: begin if (trig) m_ov = 1'b1; m_phase = 0; m_fd = 1'b1; m_busy = 1'b0; end
      endcase
      m_cnt = auto_en ? ((m_cnt == PERIOD - 1) ? 0 : m_cnt + 1) : 0;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic wait_fd(input string name, input int target, input int budget);
    int n = 0;
    while (fd_count < target && n < budget) begin cyc(1); n++; end
    chk(name, {31'd0, fd_count >= target}, 32'd1);
  endtask

  task automatic wait_bytes(input string name, input int target, input int budget);
    int n = 0;
    while (log_len < target && n < budget) begin cyc(1); n++; end
    chk(name, {31'd0, log_len >= target}, 32'd1);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_reg_addr"}, {24'd0, reg_addr}, 32'd0);
    chk({tag, "_tx_data"}, {24'd0, tx_data}, 32'd0);
    chk({tag, "_tx_valid"}, {31'd0, tx_valid}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_frame_done"}, {31'd0, frame_done}, 32'd0);
    chk({tag, "_overrun"}, {31'd0, overrun}, 32'd0);
  endtask

  initial begin
    int base, f0, o0, n;
    rst = 1'b1;
    cyc(3);
    chk_outputs_zero("reset");
    rst = 1'b0;
    cyc(2);

    // Basic frame with tx_ready held high.
    tx_ready = 1'b1;
    base = log_len; f0 = fd_count;
    pulse_start();
    wait_fd("t1_done", f0 + 1, 300);
    chk("t1_len", log_len - base, FLEN);
    chk("t1_sync", {24'd0, log_mem[base]}, 32'hA5);
    chk("t1_b1", {24'd0, log_mem[base + 1]}, 32'h5B);
    chk("t1_b2", {24'd0, log_mem[base + 2]}, 32'h58);
    chk("t1_last", {24'd0, log_mem[base + 25]}, 32'h43);
`ifdef SEQ_CHECKSUM_EN
    chk("t1_csum", {24'd0, log_mem[base + 26]}, 32'h01);
`endif
    chk("t1_busy_after", {31'd0, busy}, 32'd0);
    $display("frame basic: %0d bytes", log_len - base);

    // Random 50% backpressure.
    cyc(3);
    base = log_len; f0 = fd_count;
    tx_ready = 1'($urandom_range(0, 1));
    pulse_start();
    n = 0;
    while (fd_count == f0 && n < 1000) begin
      tx_ready = 1'($urandom_range(0, 1));
      cyc(1);
      n++;
    end
    tx_ready = 1'b1;
    chk("t2_done", {31'd0, fd_count > f0}, 32'd1);
    chk("t2_len", log_len - base, FLEN);
    chk("t2_sync", {24'd0, log_mem[base]}, 32'hA5);
    chk("t2_last", {24'd0, log_mem[base + 25]}, 32'h43);
    $display("frame backpressure: %0d bytes in %0d cycles", log_len - base, n);

    // Periodic triggering. Ticks occur at cycles 99, 199 and 299 of the window.
    cyc(3);
    f0 = fd_count;
    auto_en = 1'b1;
    cyc(380);
    chk("t3_frames", fd_count - f0, 3);
    auto_en = 1'b0;
    f0 = fd_count;
    cyc(200);
    chk("t3_stopped", fd_count - f0, 0);
    $display("auto trigger: frames stopped after auto_en low");

    // Stalled frame: each period tick is an overrun, and the frame resumes intact.
    base = log_len; f0 = fd_count; o0 = ov_count;
    tx_ready = 1'b0;
    auto_en = 1'b1;
    pulse_start();
    cyc(249);
    auto_en = 1'b0;
    chk("t4_overruns", ov_count - o0, 2);
    tx_ready = 1'b1;
    wait_fd("t4_done", f0 + 1, 300);
    chk("t4_len", log_len - base, FLEN);
    chk("t4_sync", {24'd0, log_mem[base]}, 32'hA5);
    $display("stall overrun: %0d overruns", ov_count - o0);

    // A start pulse during byte 5 is dropped and flagged.
    cyc(3);
    base = log_len; f0 = fd_count; o0 = ov_count;
    pulse_start();
    wait_bytes("t5_byte5", base + 5, 100);
    pulse_start();
    wait_fd("t5_done", f0 + 1, 300);
    cyc(100);
    chk("t5_overrun", ov_count - o0, 1);
    chk("t5_frames", fd_count - f0, 1);
    chk("t5_len", log_len - base, FLEN);
    $display("start while busy: %0d overrun", ov_count - o0);

    // Reset at byte 10 aborts the frame; the next frame starts again from the header.
    cyc(3);
    base = log_len;
    pulse_start();
    wait_bytes("t6_byte10", base + 10, 100);
    rst = 1'b1;
    #1;
    chk_outputs_zero("midreset");
    cyc(2);
    rst = 1'b0;
    cyc(2);
    base = log_len; f0 = fd_count;
    pulse_start();
    wait_fd("t6_done", f0 + 1, 300);
    chk("t6_len", log_len - base, FLEN);
    chk("t6_sync", {24'd0, log_mem[base]}, 32'hA5);
    chk("t6_last", {24'd0, log_mem[base + 25]}, 32'h43);
    $display("reset recovery: %0d bytes", log_len - base);

    cyc(5);
    chk("end_queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
